// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and latency defaults for the decode-stage stall controller.
// Pure definitions; no timing or flow control of its own.
package stall_ctrl_pkg;

    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 32;
    localparam int unsigned CNT_W        = 6;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } muldiv_op_e;

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Register $0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
        return (wr != 5'd0) && ((wr == rs) || (wr == rt));
    endfunction

endpackage

// File: rtl/stall_ctrl_muldiv_timer.sv
// Multiply/divide occupancy timer: busy for exactly MULT_LAT or DIV_LAT cycles after an accepted start.
// Start is only honoured in IDLE; done pulses in the last busy cycle.
module muldiv_timer
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_c  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div ? DIV_CNT : MULT_CNT;
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated so a reset mid-operation reads idle and never emits done.
    assign busy = rst_n && (state_q == MD_BUSY);
    assign done = rst_n && done_c;

endmodule

// File: rtl/stall_ctrl.sv
// Decode-stage hazard detector: load-use, branch-operand and mul/div structural stalls; zero-cycle latency.
// Stalls F/D and bubbles E while any hazard holds; counts stalled cycles with saturation.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RS_D,
    input  logic [4:0]  RT_D,
    input  logic        Branch_D,
    input  logic        RegWrite_E,
    input  logic [4:0]  WriteReg_E,
    input  logic [1:0]  MemtoReg_E,
    input  logic [4:0]  WriteReg_M,
    input  logic [1:0]  MemtoReg_M,
    input  logic [1:0]  MulDiv_D,
    input  logic        ReadHiLo_D,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Flush_E,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [31:0] StallCount
);

    logic        load_e, load_m;
    logic        md_op, md_start;
    logic        lu, br, sh, hz;
    logic [31:0] stall_count_q;

    assign load_e = (MemtoReg_E == MEMTOREG_LOAD);
    assign load_m = (MemtoReg_M == MEMTOREG_LOAD);
    assign md_op  = (MulDiv_D == MD_MULT) || (MulDiv_D == MD_DIV);

    assign lu = load_e && reg_hit(WriteReg_E, RS_D, RT_D);
    assign br = Branch_D && ((RegWrite_E && reg_hit(WriteReg_E, RS_D, RT_D)) ||
                             (load_m && reg_hit(WriteReg_M, RS_D, RT_D)));
    // The done cycle is still busy, so back-to-back ops and mfhi/mflo wait one more cycle.
    assign sh = MulDivBusy && (ReadHiLo_D || md_op);
    assign hz = rst_n && (lu || br || sh);

    assign Stall_F = hz;
    assign Stall_D = hz;
    assign Flush_E = hz;

    assign md_start = md_op && !hz;

    muldiv_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (MulDiv_D == MD_DIV),
        .busy   (MulDivBusy),
        .done   (MulDivDone)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (Stall_D && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: hazard vector table plus multi-cycle mul/div, reset and saturation sequences.
module tb_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RS_D, RT_D;
    logic        Branch_D;
    logic        RegWrite_E;
    logic [4:0]  WriteReg_E;
    logic [1:0]  MemtoReg_E;
    logic [4:0]  WriteReg_M;
    logic [1:0]  MemtoReg_M;
    logic [1:0]  MulDiv_D;
    logic        ReadHiLo_D;
    logic        Stall_F, Stall_D, Flush_E;
    logic        MulDivBusy, MulDivDone;
    logic [31:0] StallCount;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 32'd0;

    stall_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RS_D       (RS_D),
        .RT_D       (RT_D),
        .Branch_D   (Branch_D),
        .RegWrite_E (RegWrite_E),
        .WriteReg_E (WriteReg_E),
        .MemtoReg_E (MemtoReg_E),
        .WriteReg_M (WriteReg_M),
        .MemtoReg_M (MemtoReg_M),
        .MulDiv_D   (MulDiv_D),
        .ReadHiLo_D (ReadHiLo_D),
        .Stall_F    (Stall_F),
        .Stall_D    (Stall_D),
        .Flush_E    (Flush_E),
        .MulDivBusy (MulDivBusy),
        .MulDivDone (MulDivDone),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       rw_e;
        logic [4:0] wr_e;
        logic [1:0] m2r_e;
        logic [4:0] wr_m;
        logic [1:0] m2r_m;
        logic [1:0] md;
        logic       rhl;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RS_D = 5'd0; RT_D = 5'd0; Branch_D = 1'b0;
        RegWrite_E = 1'b0; WriteReg_E = 5'd0; MemtoReg_E = 2'b00;
        WriteReg_M = 5'd0; MemtoReg_M = 2'b00;
        MulDiv_D = 2'b00; ReadHiLo_D = 1'b0;
    endtask

    // Entered at a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle_chk(input string tag, input logic es, input logic eb, input logic ed);
        #1;
        chk({tag, "_stall_f"}, 32'(Stall_F), 32'(es));
        chk({tag, "_stall_d"}, 32'(Stall_D), 32'(es));
        chk({tag, "_flush_e"}, 32'(Flush_E), 32'(es));
        chk({tag, "_busy"},    32'(MulDivBusy), 32'(eb));
        chk({tag, "_done"},    32'(MulDivDone), 32'(ed));
        @(posedge clk);
        #1;
        if (!rst_n)
            exp_cnt = 32'd0;
        else if (es && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
        chk({tag, "_count"}, StallCount, exp_cnt);
        @(negedge clk);
    endtask

    initial begin
        //            rs     rt     br    rw_e  wr_e   m2r_e  wr_m   m2r_m  md     rhl   exp
        vecs[0]  = '{5'd3,  5'd9,  1'b0, 1'b1, 5'd3,  2'b01, 5'd0,  2'b00, 2'b00, 1'b0, 1'b1};
        vecs[1]  = '{5'd8,  5'd3,  1'b0, 1'b1, 5'd3,  2'b01, 5'd0,  2'b00, 2'b00, 1'b0, 1'b1};
        vecs[2]  = '{5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  2'b01, 5'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{5'd3,  5'd3,  1'b0, 1'b1, 5'd3,  2'b10, 5'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{5'd4,  5'd5,  1'b0, 1'b1, 5'd3,  2'b01, 5'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{5'd1,  5'd5,  1'b1, 1'b1, 5'd5,  2'b00, 5'd0,  2'b00, 2'b00, 1'b0, 1'b1};
        vecs[6]  = '{5'd1,  5'd5,  1'b1, 1'b0, 5'd0,  2'b00, 5'd5,  2'b01, 2'b00, 1'b0, 1'b1};
        vecs[7]  = '{5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  2'b00, 5'd5,  2'b01, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{5'd0,  5'd2,  1'b1, 1'b1, 5'd0,  2'b00, 5'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{5'd0,  5'd2,  1'b1, 1'b0, 5'd0,  2'b00, 5'd0,  2'b01, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{5'd1,  5'd5,  1'b1, 1'b0, 5'd0,  2'b00, 5'd5,  2'b11, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{5'd1,  5'd5,  1'b1, 1'b0, 5'd5,  2'b00, 5'd0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  2'b00, 2'b00, 1'b1, 1'b0};
        vecs[13] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  2'b00, 2'b11, 1'b0, 1'b0};

        // Reset with a live load-use hazard: outputs must stay quiet.
        rst_n = 1'b0;
        clear_inputs();
        MemtoReg_E = 2'b01; WriteReg_E = 5'd3; RS_D = 5'd3;
        @(negedge clk);
        @(negedge clk);
        cycle_chk("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_inputs();
        cycle_chk("post_reset", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            RS_D = vecs[i].rs; RT_D = vecs[i].rt; Branch_D = vecs[i].br;
            RegWrite_E = vecs[i].rw_e; WriteReg_E = vecs[i].wr_e; MemtoReg_E = vecs[i].m2r_e;
            WriteReg_M = vecs[i].wr_m; MemtoReg_M = vecs[i].m2r_m;
            MulDiv_D = vecs[i].md; ReadHiLo_D = vecs[i].rhl;
            cycle_chk($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0, 1'b0);
        end
        clear_inputs();

        // mult followed by mfhi: four busy cycles, mfhi released after done.
        MulDiv_D = 2'b01;
        cycle_chk("mult_start", 1'b0, 1'b0, 1'b0);
        MulDiv_D = 2'b00; ReadHiLo_D = 1'b1;
        for (int i = 0; i < 4; i++)
            cycle_chk($sformatf("mfhi_wait%0d", i), 1'b1, 1'b1, i == 3);
        cycle_chk("mfhi_go", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // div start held off by a load-use hazard for two cycles.
        MulDiv_D = 2'b10; MemtoReg_E = 2'b01; WriteReg_E = 5'd7; RS_D = 5'd7;
        cycle_chk("div_held0", 1'b1, 1'b0, 1'b0);
        cycle_chk("div_held1", 1'b1, 1'b0, 1'b0);
        MemtoReg_E = 2'b00;
        cycle_chk("div_start", 1'b0, 1'b0, 1'b0);
        clear_inputs();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) MulDiv_D = 2'b01;
            cycle_chk($sformatf("div_busy%0d", i), i == 31, 1'b1, i == 31);
        end
        // The mult offered in the done cycle is accepted the cycle after.
        cycle_chk("mult_after_div", 1'b0, 1'b0, 1'b0);
        MulDiv_D = 2'b00;
        for (int i = 0; i < 4; i++)
            cycle_chk($sformatf("mult2_busy%0d", i), 1'b0, 1'b1, i == 3);
        cycle_chk("mult2_idle", 1'b0, 1'b0, 1'b0);

        // Reset in the 10th div cycle aborts without a done pulse.
        MulDiv_D = 2'b10;
        cycle_chk("div2_start", 1'b0, 1'b0, 1'b0);
        MulDiv_D = 2'b00; ReadHiLo_D = 1'b1;
        for (int i = 0; i < 9; i++)
            cycle_chk($sformatf("div2_busy%0d", i), 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle_chk("div2_reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle_chk("div2_after_reset", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Saturation: preset the counter just below the top and hold a stall.
        force dut.stall_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_count_q;
        exp_cnt = 32'hFFFF_FFFD;
        MemtoReg_E = 2'b01; WriteReg_E = 5'd4; RT_D = 5'd4;
        for (int i = 0; i < 4; i++)
            cycle_chk($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0);
        chk("sat_final", StallCount, 32'hFFFF_FFFF);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
